vga_pattern_gen: RTL and testbench

Downstream consumer of the 3-bit pattern-select value that the step counter produces (values 1..4, 0 after reset). Generates 640x480@60 VGA timing from the 50 MHz system clock and renders one of four test patterns. A new selection takes effect only at the start of the next frame, so a frame never tears. Drives the board's DAC and sync pins directly.

---
 rtl/vga_pattern_gen_if.sv | 32 +++
 rtl/vga_pattern_gen.sv | 122 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Bundle between the pattern generator and the VGA DAC/sync pins.
// The generator takes the pattern select and drives everything else.
interface vga_pattern_gen_if;
  logic [2:0] sel;
  logic       vga_clk;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic       sync_n;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;

  modport master (
    input  sel,
    output vga_clk, hsync, vsync,
    output blank_n, sync_n,
    output r, g, b, x, y,
    output frame_start
  );

  modport slave (
    output sel,
    input  vga_clk, hsync, vsync,
    input  blank_n, sync_n,
    input  r, g, b, x, y,
    input  frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four frame-locked test patterns.
// Pattern select is latched only at pixel (0,0) so frames never tear.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input logic clk,
  input logic rst,
  vga_pattern_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = HS_LO + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = VS_LO + V_SYNC;
  localparam int unsigned DW      = $clog2(CLK_DIV);

  logic [DW-1:0] div;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic [2:0]    sel_q;

  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          origin;
  logic          vis;
  logic          hs_on;
  logic          vs_on;
  logic [2:0]    sel_eff;
  logic [23:0]   rgb;

  function automatic logic [23:0] bars(input logic [2:0] idx);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction

  assign tick   = (div == DW'(CLK_DIV - 1));
  assign h_last = (hcnt == 10'(H_TOTAL - 1));
  assign v_last = (vcnt == 10'(V_TOTAL - 1));
  assign origin = (hcnt == '0) && (vcnt == '0);

  assign bus.vga_clk = (div >= DW'(CLK_DIV / 2));
  assign bus.sync_n  = 1'b0;

  always_comb begin
    vis   = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
    hs_on = (hcnt >= 10'(HS_LO)) && (hcnt < 10'(HS_HI));
    vs_on = (vcnt >= 10'(VS_LO)) && (vcnt < 10'(VS_HI));
    // pixel (0,0) already renders with the newly latched select
    sel_eff = origin ? bus.sel : sel_q;
    rgb = '0;
    unique case (1'b1)
      (sel_eff == 3'd1): rgb = 24'hFF0000;
      (sel_eff == 3'd2): rgb = bars(hcnt[8:6]);
      (sel_eff == 3'd3): rgb = bars(vcnt[8:6]);
      (sel_eff == 3'd4): rgb = {24{hcnt[5] ^ vcnt[5]}};
      default:           rgb = '0;
    endcase
    if (!vis) rgb = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      div <= '0;
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q           <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.blank_n     <= 1'b0;
      bus.r           <= '0;
      bus.g           <= '0;
      bus.b           <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      if (tick) begin
        bus.hsync   <= ~hs_on;
        bus.vsync   <= ~vs_on;
        bus.blank_n <= vis;
        bus.r       <= rgb[23:16];
        bus.g       <= rgb[15:8];
        bus.b       <= rgb[7:0];
        if (vis) begin
          bus.x <= hcnt;
          bus.y <= vcnt;
        end
        if (origin) begin
          sel_q           <= bus.sel;
          bus.frame_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized-select bench for vga_pattern_gen on a shrunken raster.
// Expected outputs come from a tick-count model of the raster.
module tb_vga_pattern_gen;

  localparam int HA = 160, HF = 8, HS = 16, HB = 16;
  localparam int VA = 20, VF = 1, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [49:0] RST_VAL =
    {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 10'd0, 10'd0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  vga_pattern_gen_if vif ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_col(input int i);
    logic [23:0] c;
    c = '0;
    if ((i / 4) % 2 == 1) c[23:16] = 8'hFF;
    if ((i / 2) % 2 == 1) c[15:8]  = 8'hFF;
    if (i % 2 == 1)       c[7:0]   = 8'hFF;
    return c;
  endfunction

  function automatic logic [23:0] ref_px(input int s, input int hc,
                                         input int vc);
    if (hc >= HA || vc >= VA) return 24'h0;
    case (s)
      1: return 24'hFF0000;
      2: return bar_col((hc / 64) % 8);
      3: return bar_col((vc / 64) % 8);
      4: return (((hc / 32) + (vc / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  int          n = 0;
  int          cur_sel = 0;
  logic        e_vclk = 0, e_hs = 1, e_vs = 1, e_bn = 0, e_fs = 0;
  logic [23:0] e_rgb = '0;
  logic [9:0]  e_x = '0, e_y = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; cur_sel = 0;
      e_vclk = 0; e_hs = 1; e_vs = 1; e_bn = 0; e_fs = 0;
      e_rgb = '0; e_x = '0; e_y = '0;
    end else begin
      int k, hc, vc;
      n++;
      e_vclk = ((n % CD) >= CD / 2);
      e_fs = 0;
      if (n % CD == 0) begin
        k  = n / CD - 1;
        hc = k % HT;
        vc = (k / HT) % VT;
        if (hc == 0 && vc == 0) begin
          cur_sel = int'(vif.sel);
          e_fs = 1;
        end
        e_hs = !(hc >= HA + HF && hc < HA + HF + HS);
        e_vs = !(vc >= VA + VF && vc < VA + VF + VS);
        e_bn = (hc < HA && vc < VA);
        e_rgb = ref_px(cur_sel, hc, vc);
        if (e_bn) begin
          e_x = 10'(hc);
          e_y = 10'(vc);
        end
      end
    end
  end

  function automatic logic [49:0] observed();
    return {vif.vga_clk, vif.hsync, vif.vsync, vif.blank_n, vif.sync_n,
            vif.r, vif.g, vif.b, vif.x, vif.y, vif.frame_start};
  endfunction

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on)
      check("pixel", 64'(observed()),
            64'({e_vclk, e_hs, e_vs, e_bn, 1'b0, e_rgb, e_x, e_y, e_fs}));
  end

  // per-frame totals measured independently of the pixel model
  bit st_ok = 0;
  int c_bn = 0, c_hs = 0, c_vs = 0;
  always @(negedge clk) begin
    if (rst) begin
      st_ok = 0;
    end else if (n > 0 && n % CD == 0) begin
      if (vif.frame_start) begin
        if (st_ok) begin
          check("vis_cnt", 64'(c_bn), 64'(HA * VA));
          check("hs_cnt", 64'(c_hs), 64'(HS * VT));
          check("vs_cnt", 64'(c_vs), 64'(VS * HT));
        end
        st_ok = 1;
        c_bn = 0; c_hs = 0; c_vs = 0;
      end
      c_bn += int'(vif.blank_n);
      c_hs += int'(!vif.hsync);
      c_vs += int'(!vif.vsync);
    end
  end

  int vals[5] = '{1, 4, 2, 3, 6};

  initial begin
    vif.sel = 3'd3;
    rst = 1'b1;
    @(negedge clk);
    chk_on = 1;
    repeat (2) @(negedge clk);
    check("rst_hold", 64'(observed()), 64'(RST_VAL));
    rst = 1'b0;
    @(posedge clk); #1;
    check("fs_clk1", 64'(vif.frame_start), 64'd0);
    @(posedge clk); #1;
    check("fs_clk2", 64'(vif.frame_start), 64'd1);
    @(posedge clk); #1;
    check("fs_clk3", 64'(vif.frame_start), 64'd0);

    foreach (vals[i]) begin
      vif.sel = 3'(vals[i]);
      repeat ($urandom_range(500, 4000)) @(negedge clk);
      vif.sel = 3'($urandom_range(0, 7));
      repeat ($urandom_range(10, 300)) @(negedge clk);
      vif.sel = 3'(vals[i]);
      repeat (6000) @(negedge clk);
    end

    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async", 64'(observed()), 64'(RST_VAL));
    vif.sel = 3'd4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12000) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
